cam_ctrl: RTL and testbench

CAM_CTRL -- requirements
Module: cam_ctrl

---
 rtl/cam_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_cam_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_ctrl.sv
// cam_ctrl: arbitrates store/lookup requests onto an external append-only CAM and returns one response per request.
// Optional build macro CAM_CTRL_DUP_CHECK_EN: every write is preceded by a lookup, and keys already present are not stored again.
module cam_ctrl #(
   parameter int unsigned DATA_WIDTH    = 128,
   parameter int unsigned ADDR_WIDTH    = 5,
   parameter int unsigned SEARCH_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_key,
   input  logic                  srch_valid,
   output logic                  srch_ready,
   input  logic [DATA_WIDTH-1:0] srch_key,
   input  logic                  flush,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_op,
   output logic                  rsp_hit,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] rsp_addr,
   output logic                  cam_start,
   output logic                  cam_write_enable,
   output logic [DATA_WIDTH-1:0] cam_din,
   output logic [ADDR_WIDTH-1:0] cam_write_addr,
   input  logic                  cam_match,
   input  logic [ADDR_WIDTH-1:0] cam_match_addr,
   output logic [ADDR_WIDTH:0]   count
);
   localparam int unsigned CW    = ADDR_WIDTH + 1;
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned SCW   = 4;

   typedef enum logic [1:0] {IDLE, WRITE, SEARCH, RESP} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         count_d;
   logic                  rr_q, rr_d;
   logic                  flush_pend_q, flush_pend_d;
   logic [SCW-1:0]        scnt_q, scnt_d;
   logic                  cam_start_d, cam_write_enable_d;
   logic [DATA_WIDTH-1:0] cam_din_d;
   logic [ADDR_WIDTH-1:0] cam_write_addr_d;
   logic                  rsp_valid_d, rsp_op_d, rsp_hit_d, rsp_err_d;
   logic [ADDR_WIDTH-1:0] rsp_addr_d;
   logic                  full_c, hit_c, wr_grant_c;
`ifdef CAM_CTRL_DUP_CHECK_EN
   logic                  op_wr_q, op_wr_d;
`endif

   assign full_c     = (count == CW'(DEPTH));
   // A CAM match is only trusted inside the valid prefix; entries above count are stale.
   assign hit_c      = cam_match && ({1'b0, cam_match_addr} < count);
   assign wr_grant_c = wr_valid && (!srch_valid || !rr_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         count            <= '0;
         rr_q             <= 1'b0;
         flush_pend_q     <= 1'b0;
         scnt_q           <= '0;
         cam_start        <= 1'b0;
         cam_write_enable <= 1'b0;
         cam_din          <= '0;
         cam_write_addr   <= '0;
         rsp_valid        <= 1'b0;
         rsp_op           <= 1'b0;
         rsp_hit          <= 1'b0;
         rsp_err          <= 1'b0;
         rsp_addr         <= '0;
`ifdef CAM_CTRL_DUP_CHECK_EN
         op_wr_q          <= 1'b0;
`endif
      end else begin
         state_q          <= state_d;
         count            <= count_d;
         rr_q             <= rr_d;
         flush_pend_q     <= flush_pend_d;
         scnt_q           <= scnt_d;
         cam_start        <= cam_start_d;
         cam_write_enable <= cam_write_enable_d;
         cam_din          <= cam_din_d;
         cam_write_addr   <= cam_write_addr_d;
         rsp_valid        <= rsp_valid_d;
         rsp_op           <= rsp_op_d;
         rsp_hit          <= rsp_hit_d;
         rsp_err          <= rsp_err_d;
         rsp_addr         <= rsp_addr_d;
`ifdef CAM_CTRL_DUP_CHECK_EN
         op_wr_q          <= op_wr_d;
`endif
      end
   end

   always_comb begin
      state_d            = state_q;
      count_d            = count;
      rr_d               = rr_q;
      flush_pend_d       = flush_pend_q;
      scnt_d             = scnt_q;
      cam_start_d        = 1'b0;
      cam_write_enable_d = 1'b0;
      cam_din_d          = cam_din;
      cam_write_addr_d   = cam_write_addr;
      rsp_valid_d        = rsp_valid;
      rsp_op_d           = rsp_op;
      rsp_hit_d          = rsp_hit;
      rsp_err_d          = rsp_err;
      rsp_addr_d         = rsp_addr;
      wr_ready           = 1'b0;
      srch_ready         = 1'b0;
`ifdef CAM_CTRL_DUP_CHECK_EN
      op_wr_d            = op_wr_q;
`endif
      if (flush && state_q != IDLE) flush_pend_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (flush || flush_pend_q) begin
               count_d      = '0;
               flush_pend_d = 1'b0;
            end else if (wr_grant_c) begin
               wr_ready  = 1'b1;
               rr_d      = 1'b1;
               cam_din_d = wr_key;
`ifdef CAM_CTRL_DUP_CHECK_EN
               state_d     = SEARCH;
               cam_start_d = 1'b1;
               scnt_d      = '0;
               op_wr_d     = 1'b1;
`else
               state_d            = WRITE;
               cam_write_enable_d = !full_c;
               cam_write_addr_d   = full_c ? '0 : count[ADDR_WIDTH-1:0];
`endif
            end else if (srch_valid) begin
               srch_ready  = 1'b1;
               rr_d        = 1'b0;
               cam_din_d   = srch_key;
               state_d     = SEARCH;
               cam_start_d = 1'b1;
               scnt_d      = '0;
`ifdef CAM_CTRL_DUP_CHECK_EN
               op_wr_d     = 1'b0;
`endif
            end
         end
         WRITE: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_op_d    = 1'b1;
            rsp_hit_d   = 1'b0;
            rsp_err_d   = full_c;
            rsp_addr_d  = full_c ? '0 : count[ADDR_WIDTH-1:0];
            if (!full_c) count_d = count + CW'(1);
         end
         SEARCH: begin
            if (scnt_q == SCW'(SEARCH_CYCLES - 1)) begin
`ifdef CAM_CTRL_DUP_CHECK_EN
               // A write whose key is not already present continues into WRITE.
               if (op_wr_q && !hit_c) begin
                  state_d            = WRITE;
                  cam_write_enable_d = !full_c;
                  cam_write_addr_d   = full_c ? '0 : count[ADDR_WIDTH-1:0];
               end else begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_op_d    = op_wr_q;
                  rsp_hit_d   = hit_c;
                  rsp_err_d   = 1'b0;
                  rsp_addr_d  = hit_c ? cam_match_addr : '0;
               end
`else
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_op_d    = 1'b0;
               rsp_hit_d   = hit_c;
               rsp_err_d   = 1'b0;
               rsp_addr_d  = hit_c ? cam_match_addr : '0;
`endif
            end else begin
               cam_start_d = 1'b1;
               scnt_d      = scnt_q + SCW'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         wr_ready   = 1'b0;
         srch_ready = 1'b0;
      end
   end
endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: scoreboard bench for cam_ctrl with a behavioural CAM; follows CAM_CTRL_DUP_CHECK_EN when defined.
module tb_cam_ctrl;
   localparam int unsigned DW    = 128;
   localparam int unsigned AW    = 5;
   localparam int unsigned SC    = 2;
   localparam int unsigned DEPTH = 1 << AW;

   typedef struct {
      logic          op;
      logic          hit;
      logic          err;
      logic [AW-1:0] addr;
      int            lat;
   } exp_t;

   logic          clk, rst;
   logic          wr_valid, wr_ready, srch_valid, srch_ready, flush;
   logic [DW-1:0] wr_key, srch_key, cam_din;
   logic          rsp_valid, rsp_ready, rsp_op, rsp_hit, rsp_err;
   logic [AW-1:0] rsp_addr, cam_write_addr, cam_match_addr;
   logic          cam_start, cam_write_enable, cam_match;
   logic [AW:0]   count;

   cam_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEARCH_CYCLES(SC)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_key(wr_key),
      .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_key(srch_key),
      .flush(flush),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
      .rsp_hit(rsp_hit), .rsp_err(rsp_err), .rsp_addr(rsp_addr),
      .cam_start(cam_start), .cam_write_enable(cam_write_enable),
      .cam_din(cam_din), .cam_write_addr(cam_write_addr),
      .cam_match(cam_match), .cam_match_addr(cam_match_addr),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural CAM: keeps stale entries across flush, lowest matching address wins.
   logic [DW-1:0] cmem [DEPTH];
   logic          cvld [DEPTH];
   logic          force_match;
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) cvld[i] <= 1'b0;
      end else if (cam_write_enable) begin
         cmem[cam_write_addr] <= cam_din;
         cvld[cam_write_addr] <= 1'b1;
      end
   end
   always_comb begin
      cam_match      = 1'b0;
      cam_match_addr = '0;
      if (force_match) begin
         cam_match = 1'b1;
      end else begin
         for (int i = DEPTH - 1; i >= 0; i--)
            if (cvld[i] === 1'b1 && cmem[i] == cam_din) begin
               cam_match      = 1'b1;
               cam_match_addr = AW'(i);
            end
      end
   end

   int n_chk = 0, n_fail = 0;
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference table: valid keys occupy 0..mcount-1.
   logic [DW-1:0] mkeys [DEPTH];
   int            mcount = 0;
   exp_t          sb[$];

   task automatic push_exp(input logic is_wr, input logic [DW-1:0] key);
      exp_t e;
      int   found = -1;
      for (int i = 0; i < mcount; i++) if (found < 0 && mkeys[i] == key) found = i;
      e.hit = 1'b0; e.err = 1'b0; e.addr = '0;
      if (!is_wr) begin
         e.op  = 1'b0;
         e.lat = SC + 1;
         if (found >= 0) begin e.hit = 1'b1; e.addr = AW'(found); end
      end else begin
         e.op  = 1'b1;
         e.lat = 2;
`ifdef CAM_CTRL_DUP_CHECK_EN
         e.lat = SC + 2;
`endif
         if (found >= 0 && e.lat != 2) begin
            e.hit  = 1'b1;
            e.addr = AW'(found);
         end else if (mcount == DEPTH) begin
            e.err = 1'b1;
         end else begin
            e.addr        = AW'(mcount);
            mkeys[mcount] = key;
            mcount++;
         end
      end
      sb.push_back(e);
   endtask

   // Response monitor: pops the scoreboard on each handshake and checks latency.
   int   acc_cyc = 0, vld_cyc = 0, overlap = 0, we_pulses = 0;
   logic vld_prev = 1'b0;
   exp_t me;
   always @(negedge clk) begin
      if (rst) begin
         vld_prev = 1'b0;
      end else begin
         if ((wr_valid && wr_ready) || (srch_valid && srch_ready)) acc_cyc = cyc;
         if (rsp_valid && !vld_prev) vld_cyc = cyc;
         vld_prev = rsp_valid;
         if (cam_start && cam_write_enable) overlap++;
         if (cam_write_enable) we_pulses++;
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_rsp", 64'(1), 64'(0));
            end else begin
               me = sb.pop_front();
               check("rsp_op",   64'(rsp_op),   64'(me.op));
               check("rsp_hit",  64'(rsp_hit),  64'(me.hit));
               check("rsp_err",  64'(rsp_err),  64'(me.err));
               check("rsp_addr", 64'(rsp_addr), 64'(me.addr));
               check("latency",  64'(vld_cyc - acc_cyc), 64'(me.lat));
            end
         end
      end
   end

   task automatic wait_idle();
      for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
      if (sb.size() != 0) begin
         check("rsp_timeout", 64'(sb.size()), 64'(0));
         sb.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic req(input logic is_wr, input logic [DW-1:0] key);
      bit done = 1'b0;
      if (is_wr) begin wr_valid = 1'b1; wr_key = key; end
      else begin srch_valid = 1'b1; srch_key = key; end
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if ((is_wr && wr_ready) || (!is_wr && srch_ready)) begin
            push_exp(is_wr, key);
            done = 1'b1;
         end
      end
      if (!done) check("accept_timeout", 64'(0), 64'(1));
      @(posedge clk); #1;
      wr_valid = 1'b0; srch_valid = 1'b0;
      wait_idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] order;
      int         ng, we0, rv_seen;
      bit         got, abort_wr;
      rst = 1'b1; wr_valid = 1'b0; srch_valid = 1'b0; flush = 1'b0;
      wr_key = '0; srch_key = '0; rsp_ready = 1'b1; force_match = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_count",     64'(count),            64'(0));
      check("rst_rsp_valid", 64'(rsp_valid),        64'(0));
      check("rst_cam_start", 64'(cam_start),        64'(0));
      check("rst_cam_we",    64'(cam_write_enable), 64'(0));
      @(posedge clk); #1; rst = 1'b0;

      req(1'b1, DW'(8'hA1));
      req(1'b1, DW'(8'hB2));
      req(1'b1, DW'(8'hC3));
      @(negedge clk); check("count_3", 64'(count), 64'(mcount));
      @(posedge clk); #1;
      req(1'b0, DW'(8'hB2));
      req(1'b0, DW'(8'hFF));

      // Both requesters held: grants alternate starting with write.
      wr_key = DW'(8'hD4); srch_key = DW'(8'hB2);
      wr_valid = 1'b1; srch_valid = 1'b1; order = '0; ng = 0;
      for (int t = 0; t < 200 && ng < 4; t++) begin
         @(negedge clk);
         if (wr_ready && srch_ready) check("dual_ready", 64'(1), 64'(0));
         if (wr_ready) begin order = {order[2:0], 1'b1}; push_exp(1'b1, wr_key); ng++; end
         else if (srch_ready) begin order = {order[2:0], 1'b0}; push_exp(1'b0, srch_key); ng++; end
      end
      check("grant_cnt", 64'(ng), 64'(4));
      @(posedge clk); #1; wr_valid = 1'b0; srch_valid = 1'b0;
      wait_idle();
      check("rr_order", 64'(order), 64'(4'b1010));

      // Flush in IDLE blocks a same-cycle request; stale CAM match must not hit.
      srch_key = '0; srch_valid = 1'b1; flush = 1'b1; force_match = 1'b1;
      @(negedge clk); check("flush_blocks_req", 64'(srch_ready), 64'(0));
      @(posedge clk); #1; flush = 1'b0; mcount = 0;
      req(1'b0, '0);
      force_match = 1'b0;
      @(negedge clk); check("count_flushed", 64'(count), 64'(0));
      @(posedge clk); #1;

      for (int i = 0; i < DEPTH; i++) req(1'b1, DW'(32'h100 + i));
      @(negedge clk); check("count_full", 64'(count), 64'(DEPTH));
      @(posedge clk); #1;

      // Write into a full table, with a flush arriving while the response is stalled.
      we0 = we_pulses; rsp_ready = 1'b0; wr_key = DW'(32'h200); wr_valid = 1'b1; got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (wr_ready) begin push_exp(1'b1, wr_key); got = 1'b1; end
      end
      if (!got) check("full_accept", 64'(0), 64'(1));
      @(posedge clk); #1; wr_valid = 1'b0;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         got = rsp_valid;
      end
      if (!got) check("full_rsp_timeout", 64'(0), 64'(1));
      @(posedge clk); #1; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      @(posedge clk); #1; rsp_ready = 1'b1; mcount = 0;
      wait_idle();
      check("full_no_we", 64'(we_pulses - we0), 64'(0));
      @(negedge clk); check("count_pend_flush", 64'(count), 64'(0));
      @(posedge clk); #1;
      req(1'b1, DW'(32'h300));

`ifdef CAM_CTRL_DUP_CHECK_EN
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0; sb.delete(); mcount = 0;
      req(1'b1, DW'(8'hA1));
      req(1'b1, DW'(8'hA1));
      @(negedge clk); check("dup_count", 64'(count), 64'(1));
      @(posedge clk); #1;
      abort_wr = 1'b1;
`else
      abort_wr = 1'b0;
`endif
      // Reset while a lookup is running: no response, table cleared.
      if (abort_wr) begin wr_key = DW'(8'hE5); wr_valid = 1'b1; end
      else begin srch_key = DW'(8'hE5); srch_valid = 1'b1; end
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         got = (wr_valid && wr_ready) || (srch_valid && srch_ready);
      end
      if (!got) check("abort_accept", 64'(0), 64'(1));
      @(posedge clk); #1; wr_valid = 1'b0; srch_valid = 1'b0; rst = 1'b1;
      @(negedge clk); check("abort_in_search", 64'(cam_start), 64'(1));
      @(posedge clk); #1; rst = 1'b0; sb.delete(); mcount = 0;
      rv_seen = 0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (rsp_valid) rv_seen++;
      end
      check("abort_no_rsp", 64'(rv_seen), 64'(0));
      check("abort_count",  64'(count),   64'(mcount));
      check("no_overlap",   64'(overlap), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
